regfile_mp_sb: RTL and testbench

//  Clocked multi-port integer register file with write-through bypass and a per-register

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_read_port.sv | 32 +++
 rtl/regfile_mp_sb.sv | 101 ++++++++++
 tb/tb_regfile_mp_sb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port register file.
package rf_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = $clog2(NREG);

    typedef logic [AW-1:0]   rf_addr_t;
    typedef logic [XLEN-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One read port: zero register, then write-through bypass, then the stored array value.
module rf_read_port #(
    parameter int unsigned XLEN     = rf_pkg::XLEN,
    parameter int unsigned AW       = rf_pkg::AW,
    parameter int unsigned NW       = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [AW-1:0]      addr,
    input  logic [NW-1:0]      wr_en,
    input  logic [NW*AW-1:0]   wr_addr,
    input  logic [NW*XLEN-1:0] wr_data,
    input  logic [XLEN-1:0]    arr_data,
    output logic [XLEN-1:0]    data,
    output logic               hit
);

    // Later ports overwrite earlier matches, so the highest-index writer is forwarded.
    always_comb begin
        data = arr_data;
        hit  = 1'b0;
        for (int j = 0; j < NW; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
                data = wr_data[j*XLEN +: XLEN];
                hit  = 1'b1;
            end
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass and a per-register busy scoreboard.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = rf_pkg::XLEN,
    parameter int unsigned NREG     = rf_pkg::NREG,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NR*AW-1:0]   rd_addr,
    output logic [NR*XLEN-1:0] rd_data,
    output logic [NR-1:0]      rd_busy,
    input  logic [NW-1:0]      wr_en,
    input  logic [NW*AW-1:0]   wr_addr,
    input  logic [NW*XLEN-1:0] wr_data,
    input  logic               iss_en,
    input  logic [AW-1:0]      iss_addr,
    output logic [AW:0]        busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [NR-1:0]   rd_hit;

    // Array update; later ports are assigned last, so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0))) begin
                    regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Next busy vector: writebacks clear first, a new issue sets after so it wins a race.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NW; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
        cnt_d = '0;
        for (int k = 0; k < NREG; k++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[k]};
        end
    end

    // Scoreboard and its popcount move together on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];

        rf_read_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NW       (NW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .addr     (a),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .arr_data (regs_q[a]),
            .data     (rd_data[i*XLEN +: XLEN]),
            .hit      (rd_hit[i])
        );

        // A forwarded operand is available now, so it is never reported busy.
        assign rd_busy[i] = busy_q[a] & ~rd_hit[i];
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb with two read and two write ports.
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*XLEN-1:0] rd_data;
    logic [NR-1:0]      rd_busy;
    logic [NW-1:0]      wr_en;
    logic [NW*AW-1:0]   wr_addr;
    logic [NW*XLEN-1:0] wr_data;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic [AW:0]        busy_cnt;

    regfile_mp_sb #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    // kind 0: rd_data[port], 1: rd_busy[port], 2: busy_cnt
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every queued expectation refers to the state presented in this half cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = exp_q.pop_front();
            case (e.kind)
                0:       got = rd_data[e.port*XLEN +: XLEN];
                1:       got = {31'b0, rd_busy[e.port]};
                default: got = {26'b0, busy_cnt};
            endcase
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%h want=%h", e.name, got, e.val);
            end
        end
    end

    task automatic exp_data(input string n, input int p, input logic [31:0] v);
        exp_q.push_back('{n, 0, p, v});
    endtask

    task automatic exp_busy(input string n, input int p, input logic v);
        exp_q.push_back('{n, 1, p, {31'b0, v}});
    endtask

    task automatic exp_cnt(input string n, input int v);
        exp_q.push_back('{n, 2, 0, v});
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [31:0] d);
        wr_en[p]                = 1'b1;
        wr_addr[p*AW +: AW]     = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int a);
        iss_en   = 1'b1;
        iss_addr = AW'(a);
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // 1: everything reads zero after reset; r0 ignores writes
        exp_cnt("reset_cnt", 0);
        for (int a = 0; a < NREG; a++) begin
            set_rd(0, a); set_rd(1, NREG - 1 - a);
            exp_data("reset_rd0", 0, 32'h0);
            exp_data("reset_rd1", 1, 32'h0);
            exp_busy("reset_busy0", 0, 1'b0);
            tick();
        end
        set_wr(0, 0, 32'hDEAD_BEEF); set_rd(0, 0);
        exp_data("r0_bypass", 0, 32'h0);
        tick(); idle();
        exp_data("r0_stored", 0, 32'h0);
        tick();

        // 2: same-cycle bypass then storage
        set_wr(0, 5, 32'h1234_5678); set_rd(1, 5);
        exp_data("bypass_r5", 1, 32'h1234_5678);
        tick(); idle();
        exp_data("stored_r5", 1, 32'h1234_5678);
        tick();

        // 3: both ports write r7, port 1 wins
        set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7);
        exp_data("collide_bypass", 0, 32'h22);
        tick(); idle();
        exp_data("collide_stored", 0, 32'h22);
        tick();

        // 4: issue r9, then write it back
        issue(9);
        tick(); idle(); set_rd(0, 9);
        exp_busy("sb_busy_r9", 0, 1'b1);
        exp_cnt("sb_cnt1", 1);
        tick();
        set_wr(0, 9, 32'hAB);
        exp_busy("sb_wb_busy", 0, 1'b0);
        exp_data("sb_wb_data", 0, 32'hAB);
        exp_cnt("sb_wb_cnt_before", 1);
        tick(); idle();
        exp_cnt("sb_cnt0", 0);
        exp_busy("sb_after_busy", 0, 1'b0);
        tick();

        // 5: write and issue of r3 in one cycle leaves it busy
        issue(3);
        tick(); idle(); set_rd(1, 3);
        exp_cnt("race_cnt_pre", 1);
        tick();
        set_wr(1, 3, 32'h33); issue(3);
        exp_busy("race_inflight", 1, 1'b0);
        tick(); idle();
        exp_busy("race_busy_r3", 1, 1'b1);
        exp_cnt("race_cnt_post", 1);
        exp_data("race_data_r3", 1, 32'h33);
        tick();

        // 6: load data, mark r1..r4 busy, then reset with a write and issue pending
        set_wr(0, 1, 32'h101); set_wr(1, 2, 32'h102);
        tick();
        set_wr(0, 4, 32'h104); wr_en[1] = 1'b0;
        tick(); idle();
        issue(1); tick();
        issue(2); tick();
        issue(4); tick();
        issue(3); tick(); idle();
        set_rd(0, 2); set_rd(1, 4);
        exp_cnt("pre_rst_cnt4", 4);
        exp_data("pre_rst_r2", 0, 32'h102);
        exp_busy("pre_rst_busy_r4", 1, 1'b1);
        tick();
        rst = 1'b1; set_wr(0, 1, 32'hFFFF); issue(5);
        tick();
        rst = 1'b0; idle();
        exp_cnt("rst_cnt", 0);
        tick();
        for (int a = 1; a <= 5; a++) begin
            set_rd(0, a); set_rd(1, a);
            exp_data("rst_data", 0, 32'h0);
            exp_busy("rst_busy", 1, 1'b0);
            tick();
        end

        // Bounded drain of outstanding expectations
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
